bsg_nasti_client_resp_fifo: RTL and testbench
=============================================

# bsg_nasti_client_resp_fifo

Parametrised NASTI read-response egress for the client side of the tunnel. Takes demuxed response packets from the tunnel, buffers them in an `els_p`-deep FIFO and drives the NASTI R channel. A per-burst beat counter regenerates `last`, catches truncated bursts and ID changes inside a burst, and reports these as SLVERR. It replaces the fixed-width, unbuffered pass-through converter.

## Interface
Parameters:
- `data_width_p`, 64: R data width.
- `id_width_p`, 5: R ID width.
- `els_p`, 4: FIFO depth; must be a power of 2 and ≥ 2.
- `max_beats_p`, 8: maximum beats per burst; must be ≥ 2.

Ports:
- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  reset, asynchronous, active-low.
- `resp_valid_i`  in  1  tunnel response valid.
- `resp_data_i`  in  `1+id_width_p+data_width_p`  packet laid out as {last, id, data}, with data in the LSBs.
- `resp_yumi_o`  out  1  packet consumed this cycle.
- `nasti_r_valid_o`  out  1  R valid.
- `nasti_r_ready_i`  in  1  R ready.
- `nasti_r_id_o`  out  `id_width_p`  R ID.
- `nasti_r_data_o`  out  `data_width_p`  R data.
- `nasti_r_last_o`  out  1  R last.
- `nasti_r_resp_o`  out  2  R response: 2'd0 OKAY, 2'd2 SLVERR.
- `count_o`  out  `$clog2(els_p+1)`  FIFO occupancy.
- `err_o`  out  1  sticky protocol-error flag.

## Operation
- Enqueue condition: `resp_yumi_o = resp_valid_i & (count_o != els_p | (nasti_r_valid_o & nasti_r_ready_i))`.
  - Enqueue is therefore allowed when the FIFO is full, provided a dequeue happens in the same cycle.
- Dequeue: occurs when `nasti_r_valid_o & nasti_r_ready_i`. `nasti_r_valid_o = (count_o != 0)`.
  - With bypass compiled in, the bypass rule in Configuration also applies.
- Each FIFO entry holds {resp[1:0], last, id, data}. Read and write pointers are `$clog2(els_p)` bits wide and wrap naturally.
- While `nasti_r_valid_o` is 0, the R fields `id`, `data`, `last` and `resp` are driven to 0.
- The burst tracker runs on the enqueue side, with state IDLE/BURST, counter `beat_cnt` (`$clog2(max_beats_p)` bits) and register `burst_id_r`. On each enqueued beat:
  - In IDLE: capture the packet ID into `burst_id_r`.
  - Effective last: `eff_last = pkt.last | (beat_cnt == max_beats_p-1)`.
  - `resp = 2'd2` if the packet has `last=0` and `beat_cnt == max_beats_p-1` (forced truncation).
  - `resp = 2'd2` if in BURST and `pkt.id != burst_id_r` (ID switch). The stored ID is the packet's own ID.
  - Otherwise `resp = 2'd0`.
  - If `eff_last`: go to IDLE and clear `beat_cnt` to 0. Otherwise: go to BURST and increment `beat_cnt`.
- `err_o` sets on the cycle any SLVERR beat is enqueued. Only reset clears it.
- Beats are never dropped or reordered.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert) gives:
  - FIFO empty, `count_o` = 0, `nasti_r_valid_o` = 0 and all R fields 0.
  - `resp_yumi_o` = 0 while reset is asserted.
  - `err_o` = 0, state IDLE, `beat_cnt` = 0.
- Reset asserted mid-burst discards all buffered beats and the tracker state.
- Latency without bypass: a beat enqueued in cycle N appears on R in cycle N+1 at the earliest.
- Throughput: one beat per cycle in steady state, including at full and at empty.
- `count_o` changes by +1 on enqueue only, −1 on dequeue only, and stays the same when both occur in one cycle.
- Once `nasti_r_valid_o` is asserted, R fields must hold stable until the handshake completes.
- `resp_yumi_o` is combinational from `resp_valid_i`, `nasti_r_ready_i` and state. There is no combinational path from `resp_data_i` to `resp_yumi_o`.

## Configuration
- Macro: `BSG_NASTI_RESP_BYPASS_EN`.
- Defined:
  - When the FIFO is empty and `resp_valid_i` = 1, the input beat drives R in the same cycle: `nasti_r_valid_o` = 1, with `last` and `resp` computed by the tracker.
  - If `nasti_r_ready_i` = 1, the beat is yumi'd and not written to the FIFO (zero latency).
  - If `nasti_r_ready_i` = 0, the beat is written to the FIFO and the bypass path drops out from the next cycle.
- Undefined: no combinational path from the tunnel input to R; minimum latency is 1 cycle.

## Test plan
- Reset, then a 4-beat burst with id=3, data 0x10..0x13, last on beat 3, `ready` held at 1 -> R emits 4 beats with id=3, `last` only on the 4th, resp=0, `err_o`=0. Latency is 1 cycle, or 0 with bypass.
- `ready`=0 while 6 beats are offered, `els_p`=4 -> `resp_yumi_o` drops after 4 beats and `count_o`=4. Raise `ready` -> all 6 beats emerge in order; with `resp_valid_i` held, `count_o` stays at 4 during simultaneous enqueue/dequeue.
- `max_beats_p`=8 and 9 beats with `last`=0 -> the 8th beat comes out with last=1 and resp=2, `err_o`=1. The 9th beat starts a new burst.
- Burst starts with id=1 and its 2nd beat carries id=2 -> the 2nd beat comes out with resp=2 and id=2, and `err_o` stays 1 until reset.
- Assert `reset_n_i` with 3 beats buffered -> immediately `nasti_r_valid_o`=0 and `count_o`=0. After release, a new 1-beat burst (last=1) comes out with resp=0.
- Random `valid`/`ready` for 10k cycles -> R sequence matches a scoreboard model exactly, with no loss or duplication.

Source files
------------

// File: rtl/bsg_nasti_client_resp_fifo.sv
// NASTI read-response egress: buffers tunnel response beats in an els_p-deep FIFO and
// regenerates last/SLVERR per burst. Optional same-cycle bypass: BSG_NASTI_RESP_BYPASS_EN.
module bsg_nasti_client_resp_fifo #(
  parameter int data_width_p = 64,
  parameter int id_width_p   = 5,
  parameter int els_p        = 4,
  parameter int max_beats_p  = 8
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               resp_valid_i,
  input  logic [1+id_width_p+data_width_p-1:0] resp_data_i,
  output logic                               resp_yumi_o,
  output logic                               nasti_r_valid_o,
  input  logic                               nasti_r_ready_i,
  output logic [id_width_p-1:0]              nasti_r_id_o,
  output logic [data_width_p-1:0]            nasti_r_data_o,
  output logic                               nasti_r_last_o,
  output logic [1:0]                         nasti_r_resp_o,
  output logic [$clog2(els_p+1)-1:0]         count_o,
  output logic                               err_o
);

  localparam int pkt_w_lp  = 1 + id_width_p + data_width_p;
  localparam int ent_w_lp  = 2 + pkt_w_lp;
  localparam int ptr_w_lp  = $clog2(els_p);
  localparam int cnt_w_lp  = $clog2(els_p + 1);
  localparam int beat_w_lp = $clog2(max_beats_p);

  localparam logic [cnt_w_lp-1:0]  full_c      = cnt_w_lp'(els_p);
  localparam logic [cnt_w_lp-1:0]  empty_c     = {cnt_w_lp{1'b0}};
  localparam logic [beat_w_lp-1:0] last_beat_c = beat_w_lp'(max_beats_p - 1);
  localparam logic [0:0]           state_idle  = 1'b0;
  localparam logic [0:0]           state_burst = 1'b1;
  localparam logic [1:0]           resp_okay   = 2'd0;
  localparam logic [1:0]           resp_slverr = 2'd2;

  function automatic logic [1:0] calc_resp(input logic trunc, input logic id_switch);
    if (trunc || id_switch) begin
      calc_resp = resp_slverr;
    end else begin
      calc_resp = resp_okay;
    end
  endfunction

  logic [ent_w_lp-1:0]   mem_r [els_p];
  logic [ptr_w_lp-1:0]   wr_ptr_r, rd_ptr_r;
  logic [cnt_w_lp-1:0]   count_r;
  logic [0:0]            state_r;
  logic [beat_w_lp-1:0]  beat_cnt_r;
  logic [id_width_p-1:0] burst_id_r;
  logic                  err_r;

  logic                  pkt_last_s;
  logic [id_width_p-1:0] pkt_id_s;
  logic                  at_max_s, id_sw_s, trunc_s, eff_last_s;
  logic [1:0]            resp_s;
  logic                  bypass_s, r_valid_s, deq_s, enq_s, wr_en_s, rd_en_s;
  logic [ent_w_lp-1:0]   in_ent_s, head_s;

  // Burst tracker view of the incoming packet
  always_comb begin
    pkt_last_s = resp_data_i[pkt_w_lp-1];
    pkt_id_s   = resp_data_i[data_width_p +: id_width_p];
    at_max_s   = (beat_cnt_r == last_beat_c);
    id_sw_s    = (state_r == state_burst) && (pkt_id_s != burst_id_r);
    trunc_s    = !pkt_last_s && at_max_s;
    eff_last_s = pkt_last_s | at_max_s;
    resp_s     = calc_resp(trunc_s, id_sw_s);
    in_ent_s   = {resp_s, eff_last_s, resp_data_i[pkt_w_lp-2:0]};
  end

  // Handshake: yumi never looks at resp_data_i, only valid, ready and state
  always_comb begin
`ifdef BSG_NASTI_RESP_BYPASS_EN
    bypass_s  = reset_n_i & resp_valid_i & (count_r == empty_c);
    r_valid_s = (count_r != empty_c) | bypass_s;
`else
    bypass_s  = 1'b0;
    r_valid_s = (count_r != empty_c);
`endif
    deq_s   = r_valid_s & nasti_r_ready_i;
    enq_s   = reset_n_i & resp_valid_i & ((count_r != full_c) | deq_s);
    wr_en_s = enq_s & ~(bypass_s & nasti_r_ready_i);
    rd_en_s = deq_s & ~bypass_s;
  end

  // R channel drive; fields forced to zero while idle
  always_comb begin
    if (bypass_s) begin
      head_s = in_ent_s;
    end else begin
      head_s = mem_r[rd_ptr_r];
    end
    if (r_valid_s) begin
      nasti_r_resp_o = head_s[ent_w_lp-1 -: 2];
      nasti_r_last_o = head_s[pkt_w_lp-1];
      nasti_r_id_o   = head_s[data_width_p +: id_width_p];
      nasti_r_data_o = head_s[data_width_p-1:0];
    end else begin
      nasti_r_resp_o = 2'd0;
      nasti_r_last_o = 1'b0;
      nasti_r_id_o   = {id_width_p{1'b0}};
      nasti_r_data_o = {data_width_p{1'b0}};
    end
  end

  assign resp_yumi_o     = enq_s;
  assign nasti_r_valid_o = r_valid_s;
  assign count_o         = count_r;
  assign err_o           = err_r;

  // Storage array; contents are don't-care until counted in
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= in_ent_s;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= {ptr_w_lp{1'b0}};
      rd_ptr_r <= {ptr_w_lp{1'b0}};
      count_r  <= empty_c;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + ptr_w_lp'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + ptr_w_lp'(1);
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + cnt_w_lp'(1);
        2'b01:   count_r <= count_r - cnt_w_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Burst tracker and sticky error, advanced on every accepted beat
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= state_idle;
      beat_cnt_r <= {beat_w_lp{1'b0}};
      burst_id_r <= {id_width_p{1'b0}};
      err_r      <= 1'b0;
    end else if (enq_s) begin
      if (state_r == state_idle) begin
        burst_id_r <= pkt_id_s;
      end
      if (eff_last_s) begin
        state_r    <= state_idle;
        beat_cnt_r <= {beat_w_lp{1'b0}};
      end else begin
        state_r    <= state_burst;
        beat_cnt_r <= beat_cnt_r + beat_w_lp'(1);
      end
      err_r <= err_r | (resp_s == resp_slverr);
    end
  end

endmodule

// File: tb/tb_bsg_nasti_client_resp_fifo.sv
// Scoreboard bench for bsg_nasti_client_resp_fifo: directed bursts plus random valid/ready traffic.
module tb_bsg_nasti_client_resp_fifo;
  localparam int DW  = 64;
  localparam int IW  = 5;
  localparam int ELS = 4;
  localparam int MB  = 8;
  localparam int PW  = 1 + IW + DW;
  localparam int CW  = $clog2(ELS + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          resp_valid;
  logic [PW-1:0] resp_data;
  logic          yumi;
  logic          r_valid, r_ready;
  logic [IW-1:0] r_id;
  logic [DW-1:0] r_data;
  logic          r_last;
  logic [1:0]    r_resp;
  logic [CW-1:0] count;
  logic          err;

  bsg_nasti_client_resp_fifo #(.data_width_p(DW), .id_width_p(IW), .els_p(ELS), .max_beats_p(MB)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .resp_valid_i(resp_valid), .resp_data_i(resp_data),
    .resp_yumi_o(yumi), .nasti_r_valid_o(r_valid), .nasti_r_ready_i(r_ready),
    .nasti_r_id_o(r_id), .nasti_r_data_o(r_data), .nasti_r_last_o(r_last),
    .nasti_r_resp_o(r_resp), .count_o(count), .err_o(err));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] pend[$];
  logic [PW+1:0] sb[$];
  int   nbeat = 0;
  logic [IW-1:0] bid = '0;
  logic err_exp = 1'b0;
  int   vmode = 1;
  int   rmode = 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic last, input logic [IW-1:0] id, input logic [DW-1:0] d);
    return {last, id, d};
  endfunction

  // Reference: position within burst decides last/resp
  task automatic model_accept(input logic [PW-1:0] pkt);
    logic [IW-1:0] id;
    logic last, trunc, sw, eff;
    logic [1:0] resp;
    id    = pkt[DW +: IW];
    last  = pkt[PW-1];
    if (nbeat == 0) bid = id;
    trunc = !last && (nbeat == MB - 1);
    sw    = (nbeat != 0) && (id != bid);
    eff   = last || (nbeat == MB - 1);
    resp  = (trunc || sw) ? 2'd2 : 2'd0;
    sb.push_back({resp, eff, pkt[PW-2:0]});
    if (resp == 2'd2) err_exp = 1'b1;
    nbeat = eff ? 0 : nbeat + 1;
  endtask

  task automatic tick();
    logic exp_rv, exp_yumi;
    logic [DW-1:0] rd;
    @(posedge clk);
    #1;
    rd = {$urandom, $urandom};
    resp_valid = (pend.size() > 0) && (vmode == 1 || $urandom_range(0, 1) == 1);
    resp_data  = (pend.size() > 0) ? pend[0] : {1'b0, 5'd0, rd};
    r_ready    = (rmode == 2) ? ($urandom_range(0, 1) == 1) : (rmode == 1);
    @(negedge clk);
    exp_rv = (sb.size() > 0);
`ifdef BSG_NASTI_RESP_BYPASS_EN
    exp_rv = exp_rv || resp_valid;
`endif
    chk("count", 128'(count), 128'(sb.size()));
    chk("r_valid", 128'(r_valid), 128'(exp_rv));
    chk("err", 128'(err), 128'(err_exp));
    exp_yumi = resp_valid && ((sb.size() < ELS) || (exp_rv && r_ready));
    chk("yumi", 128'(yumi), 128'(exp_yumi));
    if (yumi && resp_valid && pend.size() > 0) model_accept(pend.pop_front());
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((pend.size() > 0 || sb.size() > 0) && n < bound) begin
      tick();
      n++;
    end
    if (pend.size() > 0 || sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pend %0d sb %0d left after %0d cycles", pend.size(), sb.size(), bound);
      pend.delete();
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n    = 1'b0;
    resp_valid = 1'b1;
    r_ready    = 1'b1;
    #1;
    chk("rst_valid", 128'(r_valid), 128'(0));
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_yumi", 128'(yumi), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_fields", 128'({r_resp, r_last, r_id, r_data}), 128'(0));
    pend.delete();
    sb.delete();
    nbeat   = 0;
    err_exp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n    = 1'b1;
    resp_valid = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every R handshake
  always @(negedge clk) begin
    #1;
    if (reset_n) begin
      if (r_valid && r_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL r_unexpected: id %0h data %0h with empty scoreboard", r_id, r_data);
        end else begin
          chk("r_beat", 128'({r_resp, r_last, r_id, r_data}), 128'(sb.pop_front()));
        end
      end else if (!r_valid) begin
        chk("r_idle_zero", 128'({r_resp, r_last, r_id, r_data}), 128'(0));
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    r_ready    = 1'b0;
    do_reset();

    // 4-beat burst, id 3, ready held
    rmode = 1; vmode = 1;
    for (int i = 0; i < 4; i++) pend.push_back(mk(i == 3, 5'd3, 64'h10 + 64'(i)));
    drain(50);
    chk("err_clean", 128'(err), 128'(0));

    // Fill with ready low, then release
    rmode = 0;
    for (int i = 0; i < 6; i++) pend.push_back(mk(i == 5, 5'd5, 64'h100 + 64'(i)));
    repeat (8) tick();
    chk("full_count", 128'(count), 128'(ELS));
    rmode = 1;
    drain(50);

    // 9 beats without last: 8th truncated, 9th opens a new burst
    for (int i = 0; i < 9; i++) pend.push_back(mk(1'b0, 5'd7, 64'h200 + 64'(i)));
    pend.push_back(mk(1'b1, 5'd7, 64'h209));
    drain(50);
    chk("err_trunc", 128'(err), 128'(1));

    // ID switch on second beat
    pend.push_back(mk(1'b0, 5'd1, 64'h300));
    pend.push_back(mk(1'b1, 5'd2, 64'h301));
    drain(50);
    chk("err_sticky", 128'(err), 128'(1));

    // Reset with three beats buffered
    rmode = 0;
    for (int i = 0; i < 3; i++) pend.push_back(mk(1'b0, 5'd6, 64'h400 + 64'(i)));
    repeat (5) tick();
    chk("pre_rst_count", 128'(count), 128'(3));
    do_reset();
    rmode = 1;
    pend.push_back(mk(1'b1, 5'd4, 64'h500));
    drain(50);
    chk("err_after_rst", 128'(err), 128'(0));

    // Random traffic
    vmode = 0; rmode = 2;
    for (int c = 0; c < 10000; c++) begin
      if (pend.size() < 4) begin
        logic [IW-1:0] rid;
        logic [DW-1:0] rdat;
        rid  = IW'($urandom_range(0, 3));
        rdat = {$urandom, $urandom};
        pend.push_back(mk($urandom_range(0, 3) == 0, rid, rdat));
      end
      tick();
    end
    vmode = 1; rmode = 1;
    drain(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
